// File: rtl/subleq_mem_arbiter_pkg.sv
// rtl/subleq_mem_arbiter_pkg.sv - shared states, owner ids and width default for the memory arbiter
package subleq_mem_arbiter_pkg;

    localparam int WORD_SIZE_DEFAULT = 16;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_RESP   = 2'd2
    } arb_state_t;

    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_DBG = 1'b1;

endpackage

// File: rtl/subleq_mem_arbiter_arb_rr2.sv
// rtl/subleq_mem_arbiter_arb_rr2.sv - combinational two-way round-robin picker
module arb_rr2 (
    input  logic [1:0] elig,
    input  logic       last,
    output logic       gnt_valid,
    output logic       gnt_id
);

    always_comb begin
        gnt_valid = |elig;
        // On contention the requester that was not served last wins
        if (elig == 2'b11) begin
            gnt_id = ~last;
        end else begin
            gnt_id = elig[1];
        end
    end

endmodule

// File: rtl/subleq_mem_arbiter.sv
// rtl/subleq_mem_arbiter.sv - shares the single memory port between the CPU and the debug/loader port
module subleq_mem_arbiter
    import subleq_mem_arbiter_pkg::*;
#(
    parameter int WORD_SIZE = WORD_SIZE_DEFAULT
) (
    input  logic                 clk,
    input  logic                 areset,
    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [WORD_SIZE-1:0] cpu_addr,
    input  logic [WORD_SIZE-1:0] cpu_wdata,
    output logic                 cpu_ack,
    output logic [WORD_SIZE-1:0] cpu_rdata,
    input  logic                 dbg_req,
    input  logic                 dbg_we,
    input  logic [WORD_SIZE-1:0] dbg_addr,
    input  logic [WORD_SIZE-1:0] dbg_wdata,
    input  logic                 dbg_lock,
    output logic                 dbg_ack,
    output logic [WORD_SIZE-1:0] dbg_rdata,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic                 mem_we,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    output logic                 owner,
    output logic                 busy
);

    arb_state_t           state;
    arb_state_t           state_nxt;
    logic                 owner_q;
    logic                 last_q;
    logic                 pl_we;
    logic [WORD_SIZE-1:0] pl_addr;
    logic [WORD_SIZE-1:0] pl_wdata;

    logic [1:0]           elig;
    logic                 gnt_valid;
    logic                 gnt_id;
    logic                 grant;

    always_comb begin
        elig = {dbg_req, cpu_req & ~dbg_lock};
        // In RESP the owner's request is the one being acked, so only the other side competes
        if (state == ARB_RESP) begin
            if (owner_q == OWNER_DBG) begin
                elig[1] = 1'b0;
            end else begin
                elig[0] = 1'b0;
            end
        end
    end

    arb_rr2 u_rr (
        .elig      (elig),
        .last      (last_q),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    always_comb begin
        grant     = 1'b0;
        state_nxt = state;
        case (state)
            ARB_IDLE: begin
                grant     = gnt_valid;
                state_nxt = gnt_valid ? ARB_ACCESS : ARB_IDLE;
            end
            ARB_ACCESS: begin
                state_nxt = ARB_RESP;
            end
            ARB_RESP: begin
                grant     = gnt_valid;
                state_nxt = gnt_valid ? ARB_ACCESS : ARB_IDLE;
            end
            default: begin
                state_nxt = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state    <= ARB_IDLE;
            owner_q  <= OWNER_CPU;
            last_q   <= OWNER_DBG;
            pl_we    <= 1'b0;
            pl_addr  <= '0;
            pl_wdata <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                owner_q  <= gnt_id;
                pl_we    <= (gnt_id == OWNER_DBG) ? dbg_we    : cpu_we;
                pl_addr  <= (gnt_id == OWNER_DBG) ? dbg_addr  : cpu_addr;
                pl_wdata <= (gnt_id == OWNER_DBG) ? dbg_wdata : cpu_wdata;
            end
            if (state == ARB_ACCESS) begin
                last_q <= owner_q;
            end
        end
    end

    // Memory-side and ack outputs decode from state and latched payload only
    assign mem_addr  = (state == ARB_ACCESS) ? pl_addr  : '0;
    assign mem_wdata = (state == ARB_ACCESS) ? pl_wdata : '0;
    assign mem_we    = (state == ARB_ACCESS) && pl_we;

    assign cpu_ack   = (state == ARB_RESP) && (owner_q == OWNER_CPU);
    assign dbg_ack   = (state == ARB_RESP) && (owner_q == OWNER_DBG);
    assign cpu_rdata = cpu_ack ? mem_rdata : '0;
    assign dbg_rdata = dbg_ack ? mem_rdata : '0;

    assign owner = owner_q;
    assign busy  = (state != ARB_IDLE);

endmodule

// File: tb/tb_subleq_mem_arbiter.sv
// tb/tb_subleq_mem_arbiter.sv - self-checking bench for subleq_mem_arbiter
module tb_subleq_mem_arbiter;

    logic        clk = 1'b0;
    logic        areset = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [15:0] cpu_addr = '0, cpu_wdata = '0;
    logic        cpu_ack;
    logic [15:0] cpu_rdata;
    logic        dbg_req = 1'b0, dbg_we = 1'b0, dbg_lock = 1'b0;
    logic [15:0] dbg_addr = '0, dbg_wdata = '0;
    logic        dbg_ack;
    logic [15:0] dbg_rdata;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;
    logic        owner, busy;

    int checks = 0;
    int failures = 0;

    subleq_mem_arbiter #(.WORD_SIZE(16)) dut (
        .clk(clk), .areset(areset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_lock(dbg_lock), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .owner(owner), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] init_word(input int i);
        return (i == 16) ? 16'h1234 : 16'(i * 16'h9e37 + 16'h1111);
    endfunction

    // Registered single-port memory, read-before-write
    logic [15:0] tb_mem [256];
    initial begin
        for (int i = 0; i < 256; i++) tb_mem[i] = init_word(i);
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            mem_rdata <= tb_mem[mem_addr[7:0]];
            if (mem_we) tb_mem[mem_addr[7:0]] <= mem_wdata;
        end
    end

    // Reference model: a timeline of arbitration opportunities plus an image of memory
    logic [15:0] ref_mem [256];
    int          m_wait = 0;
    logic [1:0]  m_excl = 2'b00;
    logic        m_last = 1'b1, m_owner = 1'b0;
    logic        e_acc = 1'b0, e_we = 1'b0;
    logic [15:0] e_addr = '0, e_wdata = '0;
    logic        e_ack = 1'b0, e_ack_id = 1'b0, e_ack_chk = 1'b0;
    logic [15:0] e_ack_data = '0;
    logic [1:0]  m_elig;
    logic        m_g;

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        forever begin
            @(posedge clk or posedge areset);
            if (areset) begin
                m_wait = 0; m_excl = 2'b00; m_last = 1'b1; m_owner = 1'b0;
                e_acc = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0;
                e_ack = 1'b0; e_ack_id = 1'b0; e_ack_chk = 1'b0; e_ack_data = '0;
            end else begin
                e_ack      = e_acc;
                e_ack_id   = m_owner;
                e_ack_chk  = e_acc && !e_we;
                e_ack_data = ref_mem[e_addr[7:0]];
                if (e_acc && e_we) ref_mem[e_addr[7:0]] = e_wdata;
                e_acc = 1'b0;
                if (m_wait > 0) begin
                    m_wait--;
                end else begin
                    m_elig[0] = cpu_req && !dbg_lock && !m_excl[0];
                    m_elig[1] = dbg_req && !m_excl[1];
                    if (m_elig != 2'b00) begin
                        m_g     = (m_elig == 2'b11) ? !m_last : m_elig[1];
                        m_owner = m_g;
                        m_last  = m_g;
                        e_acc   = 1'b1;
                        e_we    = m_g ? dbg_we    : cpu_we;
                        e_addr  = m_g ? dbg_addr  : cpu_addr;
                        e_wdata = m_g ? dbg_wdata : cpu_wdata;
                        m_wait  = 1;
                        m_excl  = m_g ? 2'b10 : 2'b01;
                    end else begin
                        m_excl = 2'b00;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Every-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            chk("m_mem_we",    mem_we,    e_acc && e_we);
            chk("m_mem_addr",  mem_addr,  e_acc ? e_addr  : 16'h0);
            chk("m_mem_wdata", mem_wdata, e_acc ? e_wdata : 16'h0);
            chk("m_cpu_ack",   cpu_ack,   e_ack && !e_ack_id);
            chk("m_dbg_ack",   dbg_ack,   e_ack && e_ack_id);
            chk("m_busy",      busy,      e_acc || e_ack);
            chk("m_owner",     owner,     m_owner);
            if (e_ack && !e_ack_id) begin
                if (e_ack_chk) chk("m_cpu_rdata", cpu_rdata, e_ack_data);
            end else begin
                chk("m_cpu_rdata0", cpu_rdata, 16'h0);
            end
            if (e_ack && e_ack_id) begin
                if (e_ack_chk) chk("m_dbg_rdata", dbg_rdata, e_ack_data);
            end else begin
                chk("m_dbg_rdata0", dbg_rdata, 16'h0);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        areset = 1'b1;
        cpu_req = 1'b0; dbg_req = 1'b0; dbg_lock = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        areset = 1'b0;
    endtask

    int n_c, n_d, seen;

    initial begin
        do_reset();
        chk("rst_busy", busy, 0);
        chk("rst_owner", owner, 0);

        // CPU alone reads 0x0010
        cyc(); cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
        cyc(); @(negedge clk);
        chk("t1_addr", mem_addr, 16'h0010);
        chk("t1_early_ack", cpu_ack, 0);
        cyc(); cpu_req = 0; @(negedge clk);
        chk("t1_ack", cpu_ack, 1);
        chk("t1_rdata", cpu_rdata, 16'h1234);
        chk("t1_dbg_ack", dbg_ack, 0);

        // Debug write then CPU read
        cyc(); dbg_req = 1; dbg_we = 1; dbg_addr = 16'h0020; dbg_wdata = 16'hBEEF;
        cyc(); @(negedge clk);
        chk("t2_we", mem_we, 1);
        chk("t2_wdata", mem_wdata, 16'hBEEF);
        cyc(); dbg_req = 0; @(negedge clk);
        chk("t2_we_once", mem_we, 0);
        chk("t2_ack", dbg_ack, 1);
        cyc(); cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0020;
        cyc(); cyc(); cpu_req = 0; @(negedge clk);
        chk("t2_readback", cpu_rdata, 16'hBEEF);

        // Simultaneous requests straight out of reset
        do_reset();
        cyc(); cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
        dbg_req = 1; dbg_we = 0; dbg_addr = 16'h0020;
        cyc(); @(negedge clk);
        chk("t3_first_owner", owner, 0);
        chk("t3_first_addr", mem_addr, 16'h0010);
        cyc(); @(negedge clk);
        chk("t3_cpu_ack", cpu_ack, 1);
        chk("t3_no_dbg_ack", dbg_ack, 0);
        cyc(); @(negedge clk);
        chk("t3_no_gap_busy", busy, 1);
        chk("t3_second_owner", owner, 1);
        chk("t3_second_addr", mem_addr, 16'h0020);
        cyc(); @(negedge clk);
        chk("t3_dbg_ack", dbg_ack, 1);
        chk("t3_dbg_rdata", dbg_rdata, 16'hBEEF);
        n_c = 0; n_d = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(); @(negedge clk);
            n_c += int'(cpu_ack);
            n_d += int'(dbg_ack);
        end
        chk("t3_alt_cpu", n_c, 2);
        chk("t3_alt_dbg", n_d, 2);
        cyc(); cpu_req = 0; dbg_req = 0;
        repeat (4) cyc();

        // dbg_lock freezes the CPU out while debug writes
        dbg_lock = 1; cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0020;
        dbg_req = 1; dbg_we = 1; dbg_addr = 16'h0040; dbg_wdata = 16'h0001;
        n_d = 0; seen = 0;
        for (int i = 0; i < 30 && n_d < 4; i++) begin
            @(negedge clk);
            if (cpu_ack) seen = 1;
            n_c = int'(dbg_ack);
            n_d += n_c;
            cyc();
            if (n_d == 4) dbg_req = 0;
            else if (n_c != 0) begin dbg_addr++; dbg_wdata++; end
        end
        chk("t4_dbg_writes", n_d, 4);
        chk("t4_cpu_frozen", seen, 0);
        dbg_lock = 0;
        seen = 0;
        for (int i = 0; i < 3 && seen == 0; i++) begin
            @(negedge clk);
            if (cpu_ack) seen = 1;
            if (seen == 0) cyc();
        end
        chk("t4_cpu_after_unlock", seen, 1);
        cyc(); cpu_req = 0;
        repeat (3) cyc();

        // Lock raised while a CPU access is in flight
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
        cyc(); dbg_lock = 1; dbg_req = 1; dbg_we = 0; dbg_addr = 16'h0020;
        @(negedge clk);
        chk("t5_cpu_owner", owner, 0);
        chk("t5_cpu_addr", mem_addr, 16'h0010);
        cyc(); cpu_req = 0; @(negedge clk);
        chk("t5_cpu_ack", cpu_ack, 1);
        chk("t5_cpu_rdata", cpu_rdata, 16'h1234);
        cyc(); @(negedge clk);
        chk("t5_dbg_owner", owner, 1);
        chk("t5_dbg_addr", mem_addr, 16'h0020);
        cyc(); dbg_req = 0; dbg_lock = 0; @(negedge clk);
        chk("t5_dbg_ack", dbg_ack, 1);
        chk("t5_dbg_rdata", dbg_rdata, 16'hBEEF);
        repeat (2) cyc();

        // Make the CPU the last-served side, then abort a CPU write with reset
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0011;
        cyc(); cyc(); cpu_req = 0;
        cyc(); cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0030; cpu_wdata = 16'h5555;
        cyc(); @(negedge clk);
        chk("t6_we_before", mem_we, 1);
        chk("t6_wdata", mem_wdata, 16'h5555);
        #1 areset = 1; cpu_req = 0;
        #1;
        chk("t6_we_drop", mem_we, 0);
        chk("t6_busy", busy, 0);
        chk("t6_owner", owner, 0);
        @(posedge clk); @(negedge clk);
        chk("t6_no_ack", cpu_ack, 0);
        areset = 0;
        cyc(); cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0030;
        dbg_req = 1; dbg_we = 0; dbg_addr = 16'h0010;
        cyc(); @(negedge clk);
        chk("t6_ptr_reset", owner, 0);
        cyc(); @(negedge clk);
        chk("t6_not_written", cpu_rdata, init_word(16'h30));

        // Randomised traffic against the model
        for (int c = 0; c < 3000; c++) begin
            cyc();
            if (cpu_req && e_ack && !e_ack_id) begin
                if ($urandom_range(0, 1) == 0) cpu_req = 0;
                else begin
                    cpu_we = 1'($urandom_range(0, 1));
                    cpu_addr = 16'($urandom_range(0, 255));
                    cpu_wdata = 16'($urandom);
                end
            end else if (!cpu_req && $urandom_range(0, 3) == 0) begin
                cpu_req = 1;
                cpu_we = 1'($urandom_range(0, 1));
                cpu_addr = 16'($urandom_range(0, 255));
                cpu_wdata = 16'($urandom);
            end
            if (dbg_req && e_ack && e_ack_id) begin
                if ($urandom_range(0, 1) == 0) dbg_req = 0;
                else begin
                    dbg_we = 1'($urandom_range(0, 1));
                    dbg_addr = 16'($urandom_range(0, 255));
                    dbg_wdata = 16'($urandom);
                end
            end else if (!dbg_req && $urandom_range(0, 3) == 0) begin
                dbg_req = 1;
                dbg_we = 1'($urandom_range(0, 1));
                dbg_addr = 16'($urandom_range(0, 255));
                dbg_wdata = 16'($urandom);
            end
            if ($urandom_range(0, 15) == 0) dbg_lock = !dbg_lock;
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
